// File: rtl/mem_arbiter_if.sv
// Cache-side request/response bundle and physical-memory bundle around mem_arbiter.
// slave is the arbiter's view; master is the surrounding caches/memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic              i_pmem_resp;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic              d_pmem_resp;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;
  logic              busy;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_resp, pmem_rdata,
    output i_pmem_resp, i_pmem_rdata, d_pmem_resp, d_pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, busy
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_resp, pmem_rdata,
    input  i_pmem_resp, i_pmem_rdata, d_pmem_resp, d_pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache; D wins by default, aging forces I after AGE_LIMIT D grants.
// Grant one cycle after the request is seen in IDLE; ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int LINE_W    = 128,
  parameter int AGE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]  perf_i_grants,
  output logic [31:0]  perf_d_grants,
  output logic [31:0]  perf_conflict_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_e;

  localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);

  state_e            state_q, state_d;
  logic [3:0]        age_q, age_d;
  logic              d_req;
  logic              i_win;
  logic              rd, wr, i_resp, d_resp;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;

  assign d_req = bus.d_pmem_read | bus.d_pmem_write;
  assign i_win = bus.i_pmem_read & (~d_req | (age_q >= AGE_LIM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

  // Memory-side outputs depend only on the registered state, never on IDLE-time requests.
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    rd      = 1'b0;
    wr      = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    addr    = '0;
    wdata   = '0;
    case (state_q)
      IDLE: begin
        if (i_win) begin
          state_d = GRANT_I;
          age_d   = '0;
        end else if (d_req) begin
          state_d = GRANT_D;
          if (bus.i_pmem_read && (age_q != 4'hF)) age_d = age_q + 4'd1;
        end
      end
      GRANT_I: begin
        rd     = bus.i_pmem_read;
        addr   = bus.i_pmem_address;
        i_resp = bus.pmem_resp;
        if (bus.pmem_resp) state_d = RELEASE;
      end
      GRANT_D: begin
        rd     = bus.d_pmem_read & ~bus.d_pmem_write;
        wr     = bus.d_pmem_write;
        addr   = bus.d_pmem_address;
        wdata  = bus.d_pmem_wdata;
        d_resp = bus.pmem_resp;
        if (bus.pmem_resp) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.pmem_read    = rd;
  assign bus.pmem_write   = wr;
  assign bus.pmem_address = addr;
  assign bus.pmem_wdata   = wdata;
  assign bus.i_pmem_resp  = i_resp;
  assign bus.d_pmem_resp  = d_resp;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;
  assign bus.busy         = (state_q != IDLE);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_q, perf_d_q, perf_c_q;
  logic        owner_d_q;
  logic        conflict;

  // In RELEASE the non-owner is whoever did not hold the grant that just finished.
  always_comb begin
    conflict = 1'b0;
    case (state_q)
      GRANT_I: conflict = d_req;
      GRANT_D: conflict = bus.i_pmem_read;
      RELEASE: conflict = owner_d_q ? bus.i_pmem_read : d_req;
      default: conflict = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_i_q  <= '0;
      perf_d_q  <= '0;
      perf_c_q  <= '0;
      owner_d_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && (state_d == GRANT_I)) begin
        perf_i_q  <= perf_i_q + 32'd1;
        owner_d_q <= 1'b0;
      end
      if ((state_q == IDLE) && (state_d == GRANT_D)) begin
        perf_d_q  <= perf_d_q + 32'd1;
        owner_d_q <= 1'b1;
      end
      if (conflict) perf_c_q <= perf_c_q + 32'd1;
    end
  end

  assign perf_i_grants        = perf_i_q;
  assign perf_d_grants        = perf_d_q;
  assign perf_conflict_cycles = perf_c_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected grants/responses are queued by the stimulus and popped by monitors.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  typedef struct { bit wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; } gexp_t;
  typedef struct { bit d_side; bit chk_rd; logic [LW-1:0] rdata; } rexp_t;

  logic          clk = 1'b0;
  logic          rst;
  int            checks = 0;
  int            errors = 0;
  int            mem_lat = 5;
  logic [LW-1:0] mem_data = '0;
  gexp_t         exp_g[$];
  rexp_t         exp_r[$];

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i, perf_d, perf_c;
`endif

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .AGE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_i_grants        (perf_i),
    .perf_d_grants        (perf_d),
    .perf_conflict_cycles (perf_c)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_g(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    gexp_t g;
    g.wr = wr; g.addr = a; g.wdata = wd;
    exp_g.push_back(g);
  endtask

  task automatic push_r(input bit d_side, input bit chk_rd, input logic [LW-1:0] rd);
    rexp_t r;
    r.d_side = d_side; r.chk_rd = chk_rd; r.rdata = rd;
    exp_r.push_back(r);
  endtask

  // I-cache: hold the request until resp; with hold, keep it one extra cycle (into RELEASE).
  task automatic i_txn(input logic [AW-1:0] a, input bit hold);
    int n = 0;
    bus.i_pmem_address = a;
    bus.i_pmem_read    = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.i_pmem_resp && n < 200);
    if (!bus.i_pmem_resp) begin
      checks++; errors++;
      $display("FAIL i_resp_timeout addr=%0h actual=no_resp required=resp", a);
    end
    if (hold) begin
      @(negedge clk);
      chk("release_pmem_read", 128'(bus.pmem_read), 128'd0);
      chk("release_busy", 128'(bus.busy), 128'd1);
    end
    bus.i_pmem_read = 1'b0;
    @(negedge clk);
    if (hold) chk("idle_after_release_busy", 128'(bus.busy), 128'd0);
  endtask

  task automatic d_txn(input logic [AW-1:0] a, input bit rd, input bit wr, input logic [LW-1:0] wd);
    int n = 0;
    bus.d_pmem_address = a;
    bus.d_pmem_wdata   = wd;
    bus.d_pmem_read    = rd;
    bus.d_pmem_write   = wr;
    do begin @(negedge clk); n++; end while (!bus.d_pmem_resp && n < 200);
    if (!bus.d_pmem_resp) begin
      checks++; errors++;
      $display("FAIL d_resp_timeout addr=%0h actual=no_resp required=resp", a);
    end
    bus.d_pmem_read  = 1'b0;
    bus.d_pmem_write = 1'b0;
    @(negedge clk);
  endtask

  // Memory: respond mem_lat cycles into a request, one-cycle resp pulse.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 128'hC0FFEE;
    forever begin
      @(posedge clk);
      #2;
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_data;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : grant_mon
    bit    prev;
    gexp_t g;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.pmem_read || bus.pmem_write) && !prev && !rst) begin
        if (exp_g.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant actual_addr=%0h required=none", bus.pmem_address);
        end else begin
          g = exp_g.pop_front();
          chk("grant_write", 128'(bus.pmem_write), 128'(g.wr));
          chk("grant_read", 128'(bus.pmem_read), 128'(!g.wr));
          chk("grant_addr", 128'(bus.pmem_address), 128'(g.addr));
          if (g.wr) chk("grant_wdata", bus.pmem_wdata, g.wdata);
        end
      end
      prev = bus.pmem_read || bus.pmem_write;
    end
  end

  initial begin : resp_mon
    rexp_t r;
    forever begin
      @(negedge clk);
      if (bus.i_pmem_resp || bus.d_pmem_resp) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual_i=%0b actual_d=%0b required=none",
                   bus.i_pmem_resp, bus.d_pmem_resp);
        end else begin
          r = exp_r.pop_front();
          chk("resp_d_side", 128'(bus.d_pmem_resp), 128'(r.d_side));
          chk("resp_i_side", 128'(bus.i_pmem_resp), 128'(!r.d_side));
          if (r.chk_rd)
            chk("resp_rdata", r.d_side ? bus.d_pmem_rdata : bus.i_pmem_rdata, r.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1;
    bus.i_pmem_read = 1'b0; bus.i_pmem_address = '0;
    bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0;
    bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_pmem_read", 128'(bus.pmem_read), 128'd0);
    chk("rst_pmem_write", 128'(bus.pmem_write), 128'd0);
    chk("rst_pmem_address", 128'(bus.pmem_address), 128'd0);
    chk("rst_pmem_wdata", bus.pmem_wdata, 128'd0);
    chk("rst_i_resp", 128'(bus.i_pmem_resp), 128'd0);
    chk("rst_d_resp", 128'(bus.d_pmem_resp), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_i_rdata_pass", bus.i_pmem_rdata, 128'hC0FFEE);
    chk("rst_d_rdata_pass", bus.d_pmem_rdata, 128'hC0FFEE);
    rst = 1'b0;
    @(negedge clk);

    // I-only read with a stale extra cycle of request after resp
    mem_data = {16{8'hA5}};
    push_g(1'b0, 16'h1230, '0);
    push_r(1'b0, 1'b1, {16{8'hA5}});
    fork
      i_txn(16'h1230, 1'b1);
      begin
        #1 chk("idle_no_comb_path", 128'(bus.pmem_read), 128'd0);
        @(negedge clk);
        chk("grant_cycle1_read", 128'(bus.pmem_read), 128'd1);
        chk("grant_cycle1_busy", 128'(bus.busy), 128'd1);
      end
    join

    // Simultaneous I read and D write, age 0: D first
    mem_data = {16{8'h3C}};
    push_g(1'b1, 16'h0200, {16{8'h55}});
    push_r(1'b1, 1'b0, '0);
    push_g(1'b0, 16'h0100, '0);
    push_r(1'b0, 1'b1, {16{8'h3C}});
    fork
      i_txn(16'h0100, 1'b0);
      d_txn(16'h0200, 1'b0, 1'b1, {16{8'h55}});
    join

    // Starvation bound: four D grants, then I, then the remaining D
    mem_data = {16{8'h96}};
    for (int k = 0; k < 4; k++) begin
      push_g(1'b0, 16'h0400 + 16'(k), '0);
      push_r(1'b1, 1'b1, {16{8'h96}});
    end
    push_g(1'b0, 16'h0300, '0);
    push_r(1'b0, 1'b1, {16{8'h96}});
    push_g(1'b0, 16'h0404, '0);
    push_r(1'b1, 1'b1, {16{8'h96}});
    fork
      i_txn(16'h0300, 1'b0);
      for (int k = 0; k < 5; k++) d_txn(16'h0400 + 16'(k), 1'b1, 1'b0, '0);
    join

    // Age must be back to 0: D wins the next conflict
    mem_data = {16{8'h5A}};
    push_g(1'b0, 16'h0210, '0);
    push_r(1'b1, 1'b1, {16{8'h5A}});
    push_g(1'b0, 16'h0110, '0);
    push_r(1'b0, 1'b1, {16{8'h5A}});
    fork
      i_txn(16'h0110, 1'b0);
      d_txn(16'h0210, 1'b1, 1'b0, '0);
    join

    // Read and write together behave as a write
    push_g(1'b1, 16'h0700, {16{8'h0F}});
    push_r(1'b1, 1'b0, '0);
    d_txn(16'h0700, 1'b1, 1'b1, {16{8'h0F}});

    // Reset in the middle of a D write
    mem_lat = 30;
    push_g(1'b1, 16'h0500, {16{8'hAA}});
    bus.d_pmem_address = 16'h0500;
    bus.d_pmem_wdata   = {16{8'hAA}};
    bus.d_pmem_write   = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_reset_write", 128'(bus.pmem_write), 128'd1);
    rst = 1'b1;
    #1;
    chk("reset_write_falls", 128'(bus.pmem_write), 128'd0);
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_address", 128'(bus.pmem_address), 128'd0);
    chk("reset_wdata", bus.pmem_wdata, 128'd0);
    bus.d_pmem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 3;
    mem_data = {16{8'hC3}};
    @(negedge clk);
    push_g(1'b0, 16'h0600, '0);
    push_r(1'b0, 1'b1, {16{8'hC3}});
    i_txn(16'h0600, 1'b0);

`ifdef ARB_PERF_CNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      push_g(1'b0, 16'h0800 + 16'(k), '0);
      push_r(1'b0, 1'b1, {16{8'hC3}});
      i_txn(16'h0800 + 16'(k), 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      push_g(1'b1, 16'h0900 + 16'(k), {16{8'h77}});
      push_r(1'b1, 1'b0, '0);
      d_txn(16'h0900 + 16'(k), 1'b0, 1'b1, {16{8'h77}});
    end
    chk("perf_i_grants", 128'(perf_i), 128'd3);
    chk("perf_d_grants", 128'(perf_d), 128'd2);
    chk("perf_conflict_cycles", 128'(perf_c), 128'd0);
`endif

    repeat (5) @(negedge clk);
    chk("grants_outstanding", 128'(exp_g.size()), 128'd0);
    chk("resps_outstanding", 128'(exp_r.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
